mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter/sequencer sharing the single-port memory (valid/ready, wr_rd, addr, wdata, rdata) among NUM_REQ requesters. Captures the winning request, drives one memory transfer at a time, and returns completion and read data to the granted requester. It sits between the requester agents and the memory slave and drives memory-side signals that are all-zero whenever idle or in reset.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 10, memory address width
- DATA_W, 32, memory data width
- WDOG_CYC, 15, watchdog limit in cycles (used only with MEM_ARB_WDOG_EN)
- clk  in  1  clock; all logic on posedge
- res  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_wr_rd  in  NUM_REQ  1=write, 0=read, per requester
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
- req_ready  out  NUM_REQ  one-hot completion pulse
- req_rdata  out  DATA_W  read data, valid with req_ready of a read
- req_err  out  1  transfer aborted, valid with req_ready
- grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
- valid, wr_rd  out  1  memory request, direction
- addr  out  ADDR_W  memory address
- wdata  out  DATA_W  memory write data
- rdata  in  DATA_W  memory read data, sampled when ready=1
- ready  in  1  memory completion

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE: if any req_valid, pick winner with round-robin starting at last_grant+1 (mod NUM_REQ); register grant_id, wr_rd, addr, wdata of winner (wdata forced 0 for reads); update last_grant; go BUS. Otherwise stay; memory outputs 0.
- BUS: valid=1, payload held stable. On ready=1: capture rdata (reads) or 0 (writes) into req_rdata register; go RESP.
- RESP: valid=0, addr/wdata/wr_rd=0; req_ready[grant_id]=1 for exactly one cycle; go IDLE.
- Requester rule: hold req_valid and payload until its req_ready. Deassertion after grant does not cancel; transfer completes and req_ready still pulses.
- Requests not granted stay pending; no requester waits more than NUM_REQ-1 other transfers.
- req_rdata holds its value until the next RESP; req_err=0 outside RESP.
- Reset values: state IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), grant_id=0, all memory outputs 0, req_ready=0, req_rdata=0, req_err=0.
- Reset mid-transfer: valid drops immediately (asynchronous); no req_ready is issued for the aborted transfer.

## Timing
- req_valid sampled at edge k in IDLE -> valid=1 from edge k+1.
- Memory returns ready at edge k+2 at earliest (one cycle after valid) -> req_ready high from edge k+2 to edge k+3.
- Minimum 3 cycles per transfer; back-to-back grants occur in IDLE immediately after RESP.
- ready while not in BUS is ignored.

## Configuration
- MEM_ARB_WDOG_EN defined: a counter clears on entry to BUS and increments each BUS cycle without ready; reaching WDOG_CYC forces RESP with req_err=1, req_rdata=0, valid dropped. ready arriving in the same cycle as timeout wins (normal completion, req_err=0).
- Undefined: no counter; BUS waits indefinitely; req_err tied 0.

## Structure
- Package mem_arb_pkg: state enum (IDLE, BUS, RESP), default widths, WDOG_CYC default.
- Sub-module mem_arb_rr: combinational round-robin picker (req vector, last_grant in -> winner index and any-valid out).

## Test plan
- Single read: req_valid=0001, addr=0x05, memory ready 1 cycle after valid, rdata=0xDEADBEEF -> valid high 1 cycle, req_ready=0001 one cycle, req_rdata=0xDEADBEEF.
- Single write: requester 2 writes 0x12345678 to 0x3FF -> addr=0x3FF, wdata=0x12345678, wr_rd=1 during BUS, req_ready=0100, then all memory outputs 0.
- Contention: req_valid=1111 held -> grant order 0,1,2,3,0; each req_ready one-hot, one transfer per 3 cycles.
- Fairness: requesters 0 and 3 continuously requesting, last_grant=0 -> next grant 3, then 0.
- Reset mid-BUS: drop res with valid=1 -> valid=0 immediately, no req_ready; after release requester 0 wins first.
- Watchdog (MEM_ARB_WDOG_EN): ready held 0 -> after 15 BUS cycles req_ready pulses with req_err=1, req_rdata=0; without the macro, valid stays high.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory arbiter.
// The watchdog is compiled in only when MEM_ARB_WDOG_EN is defined.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int NUM_REQ_DEF  = 4;
    localparam int ADDR_W_DEF   = 10;
    localparam int DATA_W_DEF   = 32;
    localparam int WDOG_CYC_DEF = 15;

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational round-robin picker: first pending requester after i_last,
// wrapping modulo NUM_REQ.
module mem_arb_rr
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int GW      = $clog2(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GW-1:0]      i_last,
    output logic [GW-1:0]      o_win,
    output logic               o_any
);

    always_comb begin
        int   w_idx;
        logic w_found;
        o_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(i_last) + k) % NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                o_win   = GW'(w_idx);
                w_found = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing one single-port memory among NUM_REQ requesters.
// Optional transfer watchdog enabled by defining MEM_ARB_WDOG_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WDOG_CYC = WDOG_CYC_DEF
)(
    input  logic                        clk,
    input  logic                        res,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_wr_rd,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           req_rdata,
    output logic                        req_err,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        valid,
    output logic                        wr_rd,
    output logic [ADDR_W-1:0]           addr,
    output logic [DATA_W-1:0]           wdata,
    input  logic [DATA_W-1:0]           rdata,
    input  logic                        ready
);

    localparam int GW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || WDOG_CYC < 1) begin : g_bad_cfg
    end

    arb_state_t        r_state;
    logic [GW-1:0]     r_last;
    logic [GW-1:0]     r_gid;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic [GW-1:0]     w_win;
    logic              w_any;
    logic              w_bus;
    logic              w_wdog_hit;
    logic [ADDR_W-1:0] w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0] w_wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign w_wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    mem_arb_rr #(.NUM_REQ(NUM_REQ), .GW(GW)) u_rr (
        .i_req  (req_valid),
        .i_last (r_last),
        .o_win  (w_win),
        .o_any  (w_any)
    );

`ifdef MEM_ARB_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] r_wdog;

    assign w_wdog_hit = (r_wdog == WD_W'(WDOG_CYC - 1));

    // Held at zero outside BUS, so every transfer starts with a fresh count.
    always_ff @(posedge clk or negedge res) begin
        if (!res)
            r_wdog <= '0;
        else if (r_state != BUS)
            r_wdog <= '0;
        else if (!ready && !w_wdog_hit)
            r_wdog <= r_wdog + 1'b1;
    end
`else
    assign w_wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= IDLE;
            r_last  <= GW'(NUM_REQ - 1);
            r_gid   <= '0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_state <= BUS;
                    r_gid   <= w_win;
                    r_last  <= w_win;
                    r_wr    <= req_wr_rd[w_win];
                    r_addr  <= w_addr_arr[w_win];
                    r_wdata <= req_wr_rd[w_win] ? w_wdata_arr[w_win] : '0;
                    r_err   <= 1'b0;
                end
                // A ready coinciding with the timeout is a normal completion.
                BUS: if (ready) begin
                    r_state <= RESP;
                    r_rdata <= r_wr ? '0 : rdata;
                    r_err   <= 1'b0;
                end else if (w_wdog_hit) begin
                    r_state <= RESP;
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Memory side decoded from state so the async reset clears it at once.
    assign w_bus     = (r_state == BUS);
    assign valid     = w_bus;
    assign wr_rd     = w_bus & r_wr;
    assign addr      = w_bus ? r_addr  : '0;
    assign wdata     = w_bus ? r_wdata : '0;
    assign grant_id  = r_gid;
    assign req_rdata = r_rdata;
    assign req_err   = (r_state == RESP) & r_err;

    always_comb begin
        req_ready = '0;
        if (r_state == RESP)
            req_ready[r_gid] = 1'b1;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with directed corner scenarios.
// Watchdog expectations follow MEM_ARB_WDOG_EN.
module tb_mem_arbiter;

    localparam int NR = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int WD = 15;

    logic                  clk = 1'b0;
    logic                  res;
    logic [NR-1:0]         req_valid;
    logic [NR-1:0]         req_wr_rd;
    logic [NR*AW-1:0]      req_addr;
    logic [NR*DW-1:0]      req_wdata;
    logic [NR-1:0]         req_ready;
    logic [DW-1:0]         req_rdata;
    logic                  req_err;
    logic [$clog2(NR)-1:0] grant_id;
    logic                  valid;
    logic                  wr_rd;
    logic [AW-1:0]         addr;
    logic [DW-1:0]         wdata;
    logic [DW-1:0]         rdata;
    logic                  ready;

    mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .WDOG_CYC(WD)) dut (
        .clk(clk), .res(res), .req_valid(req_valid), .req_wr_rd(req_wr_rd),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .req_rdata(req_rdata), .req_err(req_err), .grant_id(grant_id),
        .valid(valid), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [DW-1:0] rd;
        logic          err;
    } exp_t;

    exp_t    sb[$];
    int      starts[$];
    int      ready_cyc[$];
    int      errors = 0;
    int      checks = 0;
    int      cyc = 0;
    int      valid_cyc = 0;
    logic [NR-1:0] snap;

    // memory model knobs
    bit            mem_stall = 0;
    bit            noise = 0;
    bit            fixed_en = 0;
    logic [DW-1:0] fixed_val = '0;
    int            mem_dmax = 0;
    bit            auto_drop = 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Spec rule: scan requesters starting just after the last grant, wrapping.
    function automatic int rr_pick(input logic [NR-1:0] pend, input int last);
        int order[$];
        for (int i = 0; i < NR; i++) order.push_back(i);
        repeat (last + 1) order.push_back(order.pop_front());
        foreach (order[j]) if (pend[order[j]]) return order[j];
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        snap <= req_valid;
    end

    // Memory slave plus transaction-level reference of the arbitration.
    initial begin : mem_model
        int            model_last;
        int            cur;
        int            cnt;
        bit            in_xfer;
        logic          cur_wr;
        model_last = NR - 1;
        cur = 0; cnt = 0; in_xfer = 0; cur_wr = 0;
        ready = 1'b0;
        rdata = '0;
        forever begin
            @(posedge clk); #1;
            ready = 1'b0;
            if (!res) begin
                in_xfer    = 0;
                model_last = NR - 1;
            end else if (valid) begin
                if (!in_xfer) begin
                    in_xfer = 1;
                    cur = rr_pick(snap, model_last);
                    starts.push_back(int'(grant_id));
                    if (cur < 0) begin
                        chk("grant_without_request", 64'(valid), 64'd0);
                        cur = int'(grant_id);
                    end else begin
                        cur_wr = req_wr_rd[cur];
                        chk("grant_id", 64'(grant_id), 64'(cur));
                        chk("bus_wr_rd", 64'(wr_rd), 64'(cur_wr));
                        chk("bus_addr", 64'(addr), 64'(req_addr[cur*AW +: AW]));
                        chk("bus_wdata", 64'(wdata), cur_wr ? 64'(req_wdata[cur*DW +: DW]) : 64'd0);
                    end
                    model_last = cur;
                    cnt = $urandom_range(mem_dmax, 0);
`ifdef MEM_ARB_WDOG_EN
                    if (mem_stall) sb.push_back('{id: cur, rd: '0, err: 1'b1});
`endif
                end
                if (!mem_stall) begin
                    if (cnt == 0) begin
                        ready = 1'b1;
                        rdata = fixed_en ? fixed_val : DW'($urandom);
                        sb.push_back('{id: cur, rd: (cur_wr ? '0 : rdata), err: 1'b0});
                    end else begin
                        cnt--;
                    end
                end
            end else begin
                in_xfer = 0;
                if (noise) begin
                    ready = 1'($urandom_range(1, 0));
                    rdata = DW'($urandom);
                end
            end
        end
    end

    // Scoreboard monitor: pops one expectation per completion pulse.
    exp_t mon_e;
    always @(negedge clk) begin
        if (res === 1'b1) begin
            if (valid) valid_cyc++;
            if (req_ready != '0) begin
                ready_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    chk("unexpected_req_ready", 64'(req_ready), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("req_ready_onehot", 64'(req_ready), 64'd1 << mon_e.id);
                    chk("req_rdata", 64'(req_rdata), 64'(mon_e.rd));
                    chk("req_err", 64'(req_err), 64'(mon_e.err));
                end
            end else begin
                chk("req_err_idle", 64'(req_err), 64'd0);
            end
            if (!valid) chk("mem_idle_zero", 64'({wr_rd, addr, wdata}), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        if (auto_drop) req_valid &= ~req_ready;
    endtask

    task automatic issue(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_wr_rd[i] = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_rdy(input int idx, input int lim, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!req_ready[idx] && lat < lim);
        if (!req_ready[idx]) chk("wait_req_ready_timeout", 64'(req_ready), 64'd1 << idx);
    endtask

    task automatic wait_valid(input int lim);
        int n;
        n = 0;
        while (!valid && n < lim) begin
            tick();
            n++;
        end
        if (!valid) chk("wait_valid_timeout", 64'(valid), 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b0;
        sb.delete();
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        res = 1'b1;
    endtask

    task automatic run_until(input int npulses, input int lim);
        int n;
        int t;
        n = 0; t = 0;
        while (n < npulses && t < lim) begin
            tick();
            t++;
            if (req_ready != '0) n++;
        end
        if (n < npulses) chk("run_until_timeout", 64'(n), 64'(npulses));
        req_valid = '0;
        repeat (3) tick();
    endtask

    initial begin : stim
        int lat;
        int v0;
        res = 1'b0;
        req_valid = '0; req_wr_rd = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_mem_out", 64'({wr_rd, addr, wdata}), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_req_rdata", 64'(req_rdata), 64'd0);
        chk("rst_req_err", 64'(req_err), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        res = 1'b1;
        tick();

        // single read: requester 0, memory answers one cycle after valid
        fixed_en = 1; fixed_val = 32'hDEADBEEF;
        issue(0, 1'b0, 10'h005, 32'hA5A5A5A5);
        v0 = valid_cyc;
        wait_rdy(0, 10, lat);
        chk("rd_latency", 64'(lat), 64'd2);
        chk("rd_req_ready", 64'(req_ready), 64'b0001);
        chk("rd_rdata", 64'(req_rdata), 64'hDEADBEEF);
        tick();
        chk("rd_valid_cycles", 64'(valid_cyc - v0), 64'd1);

        // single write: requester 2
        issue(2, 1'b1, 10'h3FF, 32'h12345678);
        wait_valid(5);
        chk("wr_addr", 64'(addr), 64'h3FF);
        chk("wr_wdata", 64'(wdata), 64'h12345678);
        chk("wr_wr_rd", 64'(wr_rd), 64'd1);
        wait_rdy(2, 10, lat);
        chk("wr_req_ready", 64'(req_ready), 64'b0100);
        tick();
        chk("wr_after_zero", 64'({valid, wr_rd, addr, wdata}), 64'd0);

        // contention: all four held
        do_reset();
        auto_drop = 0;
        starts.delete(); ready_cyc.delete();
        for (int i = 0; i < NR; i++) issue(i, 1'($urandom), AW'($urandom), DW'($urandom));
        run_until(5, 40);
        if (starts.size() < 5 || ready_cyc.size() < 5) chk("contention_count", 64'(starts.size()), 64'd5);
        else begin
            chk("cont_g0", 64'(starts[0]), 64'd0);
            chk("cont_g1", 64'(starts[1]), 64'd1);
            chk("cont_g2", 64'(starts[2]), 64'd2);
            chk("cont_g3", 64'(starts[3]), 64'd3);
            chk("cont_g4", 64'(starts[4]), 64'd0);
            for (int i = 0; i < 4; i++)
                chk("cont_spacing", 64'(ready_cyc[i+1] - ready_cyc[i]), 64'd3);
        end

        // fairness: 0 and 3 both pending
        do_reset();
        starts.delete();
        issue(0, 1'b0, 10'h011, '0);
        issue(3, 1'b1, 10'h233, 32'hCAFEF00D);
        run_until(3, 30);
        if (starts.size() < 3) chk("fair_count", 64'(starts.size()), 64'd3);
        else begin
            chk("fair_g0", 64'(starts[0]), 64'd0);
            chk("fair_g1", 64'(starts[1]), 64'd3);
            chk("fair_g2", 64'(starts[2]), 64'd0);
        end
        auto_drop = 1;

        // reset while the bus is stalled
        mem_stall = 1;
        issue(2, 1'b0, 10'h077, '0);
        wait_valid(5);
        tick(); tick();
        @(negedge clk);
        res = 1'b0;
        sb.delete();
        #1;
        chk("rst_mid_valid", 64'(valid), 64'd0);
        chk("rst_mid_req_ready", 64'(req_ready), 64'd0);
        repeat (2) @(posedge clk);
        mem_stall = 0;
        fixed_en = 0;
        req_valid = '0;
        issue(0, 1'b0, 10'h100, '0);
        issue(2, 1'b0, 10'h077, '0);
        starts.delete();
        @(negedge clk);
        res = 1'b1;
        wait_rdy(0, 10, lat);
        if (starts.size() < 1) chk("rst_first_count", 64'd0, 64'd1);
        else chk("rst_first_grant", 64'(starts[0]), 64'd0);
        wait_rdy(2, 10, lat);
        tick();

        // stalled memory: watchdog or indefinite wait
        mem_stall = 1;
        issue(1, 1'b0, 10'h2AA, '0);
        v0 = valid_cyc;
`ifdef MEM_ARB_WDOG_EN
        wait_rdy(1, 40, lat);
        chk("wdog_err", 64'(req_err), 64'd1);
        chk("wdog_rdata", 64'(req_rdata), 64'd0);
        tick();
        chk("wdog_bus_cycles", 64'(valid_cyc - v0), 64'(WD));
        mem_stall = 0;
`else
        repeat (40) tick();
        chk("nowdog_valid_held", 64'(valid), 64'd1);
        chk("nowdog_no_ready", 64'(req_ready), 64'd0);
        mem_stall = 0;
        do_reset();
`endif
        tick();

        // randomized traffic
        noise = 1; mem_dmax = 3;
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int i = 0; i < NR; i++)
                if (!req_valid[i] && $urandom_range(3, 0) == 0)
                    issue(i, 1'($urandom), AW'($urandom), DW'($urandom));
        end
        begin
            int t;
            t = 0;
            while (!(req_valid == '0 && sb.size() == 0 && !valid) && t < 200) begin
                tick();
                t++;
            end
            chk("drain_pending", 64'(req_valid), 64'd0);
            chk("drain_scoreboard", 64'(sb.size()), 64'd0);
        end
        noise = 0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
